instr_fetch_ifid: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register of the pipelined MIPS core.
- Generates the PC and issues single-outstanding requests to instruction memory, which may have variable latency.
- Latches each returned word into IF/ID and splits out the fields.
- id_imm16 drives the 16-to-32 sign/zero-extend unit in decode.
- Handles decode stall, pipeline flush and branch/jump redirect.

---
 rtl/instr_fetch_ifid.sv | 139 +++++++++++++
 tb/tb_instr_fetch_ifid.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_ifid.sv
// Instruction fetch stage and IF/ID pipeline register. It keeps one request outstanding to a
// variable-latency instruction memory and holds fetched words while decode is stalled.
module instr_fetch_ifid #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        id_stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc4,
    output logic [4:0]  id_rs,
    output logic [4:0]  id_rt,
    output logic [4:0]  id_rd,
    output logic [15:0] id_imm16
);

    // Handshake: a fetch is accepted on a cycle with imem_req && imem_gnt; exactly one
    // imem_rvalid follows later, and no new request is raised until that response is consumed.
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fpc_q, fpc_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic [31:0] seq_pc;

    assign seq_pc = fpc_q + PC_STEP;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fpc_d   = fpc_q;
        hold_d  = hold_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;

        case (state_q)
            S_REQ: begin
                if (imem_gnt) begin
                    state_d = S_WAIT;
                    fpc_d   = pc_q;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (!id_stall) begin
                        instr_d = imem_rdata;
                        pc4_d   = seq_pc;
                        valid_d = 1'b1;
                        pc_d    = seq_pc;
                        state_d = S_REQ;
                    end else begin
                        hold_d  = imem_rdata;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!id_stall) begin
                    instr_d = hold_q;
                    pc4_d   = seq_pc;
                    valid_d = 1'b1;
                    pc_d    = seq_pc;
                    state_d = S_REQ;
                end
            end
            S_DROP: begin
                if (imem_rvalid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        // Redirect overrides everything above: IF/ID keeps its word but is marked dead, and
        // any response still owed by memory is routed through S_DROP.
        if (redirect) begin
            pc_d    = redirect_pc;
            valid_d = 1'b0;
            instr_d = instr_q;
            pc4_d   = pc4_q;
            hold_d  = hold_q;
            fpc_d   = fpc_q;
            case (state_q)
                S_REQ:   state_d = imem_gnt ? S_DROP : S_REQ;
                S_WAIT:  state_d = imem_rvalid ? S_REQ : S_DROP;
                S_HOLD:  state_d = S_REQ;
                S_DROP:  state_d = imem_rvalid ? S_REQ : S_DROP;
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            fpc_q   <= RESET_PC;
            hold_q  <= 32'h0;
            instr_q <= 32'h0;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fpc_q   <= fpc_d;
            hold_q  <= hold_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    // Gated with rst_n so no request is visible while reset is held.
    assign imem_req  = rst_n && (state_q == S_REQ);
    assign imem_addr = pc_q;

    assign id_valid = valid_q;
    assign id_instr = instr_q;
    assign id_pc4   = pc4_q;
    assign id_rs    = instr_q[25:21];
    assign id_rt    = instr_q[20:16];
    assign id_rd    = instr_q[15:11];
    assign id_imm16 = instr_q[15:0];

endmodule

// File: tb/tb_instr_fetch_ifid.sv
// Directed bench for instr_fetch_ifid: a small memory responder with adjustable grant and
// response delays, checked against hand-computed fetch addresses and IF/ID contents.
module tb_instr_fetch_ifid;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc4;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [15:0] id_imm16;

    int n_checks;
    int n_fail;

    // memory responder state
    int          gnt_lat;
    int          rsp_lat;
    int          req_age;
    int          rsp_cnt;
    bit          pending;
    logic [31:0] pend_addr;
    int          n_grant;
    logic [31:0] last_gnt_addr;

    instr_fetch_ifid dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .id_stall    (id_stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc4      (id_pc4),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_rd       (id_rd),
        .id_imm16    (id_imm16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        case (addr)
            32'h0000_0200: mem_word = 32'h2008_FFFF;
            32'h0000_0204: mem_word = 32'h340A_00AA;
            default:       mem_word = addr >> 2;
        endcase
    endfunction

    // Sets memory inputs for the current cycle; called once per cycle just after the edge.
    task automatic mem_drive();
        imem_rvalid = 1'b0;
        imem_gnt    = 1'b0;
        if (!rst_n) begin
            pending = 1'b0;
            req_age = 0;
            rsp_cnt = 0;
        end else begin
            if (pending) begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(pend_addr);
                    pending     = 1'b0;
                end
            end
            if (imem_req) begin
                if (req_age >= gnt_lat) begin
                    imem_gnt      = 1'b1;
                    pending       = 1'b1;
                    rsp_cnt       = rsp_lat;
                    pend_addr     = imem_addr;
                    last_gnt_addr = imem_addr;
                    n_grant++;
                    req_age       = 0;
                end else begin
                    req_age++;
                end
            end else begin
                req_age = 0;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        mem_drive();
    endtask

    task automatic wait_valid(input int max_cycles);
        int n;
        n = 0;
        while (!id_valid && n < max_cycles) begin
            cycle();
            n++;
        end
        chk("wait_valid_timeout", {31'h0, id_valid}, 32'h1);
    endtask

    // Redirect issued on a cycle that also grants; the drop path then recovers at target.
    task automatic redirect_from_req(input logic [31:0] target);
        redirect    = 1'b1;
        redirect_pc = target;
        cycle();
        redirect    = 1'b0;
        chk("rdr_flush_valid", {31'h0, id_valid}, 32'h0);
        chk("rdr_drop_req", {31'h0, imem_req}, 32'h0);
        cycle();
        chk("rdr_new_addr", imem_addr, target);
    endtask

    initial begin
        int n0;
        n_checks    = 0;
        n_fail      = 0;
        gnt_lat     = 0;
        rsp_lat     = 1;
        req_age     = 0;
        rsp_cnt     = 0;
        pending     = 1'b0;
        pend_addr   = 32'h0;
        n_grant     = 0;
        last_gnt_addr = 32'h0;
        rst_n       = 1'b0;
        id_stall    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;

        // reset state
        cycle();
        cycle();
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_valid", {31'h0, id_valid}, 32'h0);
        chk("rst_instr", id_instr, 32'h0);
        chk("rst_pc4", id_pc4, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        rst_n = 1'b1;
        cycle();

        // sequential fetch, one instruction every two cycles
        for (int i = 0; i < 3; i++) begin
            chk("seq_req", {31'h0, imem_req}, 32'h1);
            chk("seq_addr", imem_addr, 32'(4 * i));
            cycle();
            chk("seq_wait_req", {31'h0, imem_req}, 32'h0);
            cycle();
            chk("seq_valid", {31'h0, id_valid}, 32'h1);
            chk("seq_instr", id_instr, 32'(i));
            chk("seq_pc4", id_pc4, 32'(4 * i + 4));
        end

        // field split
        redirect_from_req(32'h0000_0200);
        chk("rdr_instr_kept", id_instr, 32'h2);
        cycle();
        cycle();
        chk("f1_instr", id_instr, 32'h2008_FFFF);
        chk("f1_rs", {27'h0, id_rs}, 32'd0);
        chk("f1_rt", {27'h0, id_rt}, 32'd8);
        chk("f1_rd", {27'h0, id_rd}, 32'd31);
        chk("f1_imm", {16'h0, id_imm16}, 32'h0000_FFFF);
        chk("f1_pc4", id_pc4, 32'h0000_0204);
        cycle();
        cycle();
        chk("f2_instr", id_instr, 32'h340A_00AA);
        chk("f2_rs", {27'h0, id_rs}, 32'd0);
        chk("f2_rt", {27'h0, id_rt}, 32'd10);
        chk("f2_imm", {16'h0, id_imm16}, 32'h0000_00AA);
        chk("f2_pc4", id_pc4, 32'h0000_0208);

        // decode stall while the word for address 20 returns
        redirect_from_req(32'h0000_0014);
        id_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_instr_hold", id_instr, 32'h340A_00AA);
            chk("stall_no_req", {31'h0, imem_req}, 32'h0);
        end
        id_stall = 1'b0;
        rsp_lat  = 3;
        cycle();
        chk("stall_rel_instr", id_instr, 32'h5);
        chk("stall_rel_pc4", id_pc4, 32'd24);
        chk("stall_rel_valid", {31'h0, id_valid}, 32'h1);
        chk("stall_next_addr", imem_addr, 32'd24);

        // redirect while waiting on a slow response
        cycle();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        cycle();
        redirect    = 1'b0;
        chk("wrdr_valid", {31'h0, id_valid}, 32'h0);
        chk("wrdr_req", {31'h0, imem_req}, 32'h0);
        cycle();
        chk("wrdr_drop_req", {31'h0, imem_req}, 32'h0);
        cycle();
        chk("wrdr_stale_instr", id_instr, 32'h5);
        chk("wrdr_stale_valid", {31'h0, id_valid}, 32'h0);
        chk("wrdr_addr", imem_addr, 32'h0000_0100);
        rsp_lat = 1;
        wait_valid(10);
        chk("wrdr_instr", id_instr, 32'h0000_0040);
        chk("wrdr_pc4", id_pc4, 32'h0000_0104);

        // grant held low for four cycles
        cycle();
        gnt_lat = 4;
        cycle();
        chk("gnt_prev_instr", id_instr, 32'h0000_0041);
        n0 = n_grant;
        for (int i = 0; i < 4; i++) begin
            chk("gnt_low_req", {31'h0, imem_req}, 32'h1);
            chk("gnt_low_addr", imem_addr, 32'h0000_0108);
            cycle();
        end
        chk("gnt_high_req", {31'h0, imem_req}, 32'h1);
        chk("gnt_high_addr", imem_addr, 32'h0000_0108);
        gnt_lat = 0;
        cycle();
        chk("gnt_after_req", {31'h0, imem_req}, 32'h0);
        chk("gnt_single", 32'(n_grant - n0), 32'd1);
        chk("gnt_gaddr", last_gnt_addr, 32'h0000_0108);
        cycle();
        chk("gnt_instr", id_instr, 32'h0000_0042);

        // PC wraps modulo 2^32
        redirect_from_req(32'hFFFF_FFFC);
        cycle();
        cycle();
        chk("wrap_instr", id_instr, 32'h3FFF_FFFF);
        chk("wrap_pc4", id_pc4, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);

        // reset asserted while holding a stalled word
        id_stall = 1'b1;
        cycle();
        cycle();
        chk("hold_instr", id_instr, 32'h3FFF_FFFF);
        rst_n = 1'b0;
        #1;
        chk("mrst_req", {31'h0, imem_req}, 32'h0);
        chk("mrst_valid", {31'h0, id_valid}, 32'h0);
        chk("mrst_instr", id_instr, 32'h0);
        chk("mrst_pc4", id_pc4, 32'h0);
        chk("mrst_imm", {16'h0, id_imm16}, 32'h0);
        id_stall = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();
        chk("mrst_first_req", {31'h0, imem_req}, 32'h1);
        chk("mrst_first_addr", imem_addr, 32'h0);
        cycle();
        cycle();
        chk("mrst_load_valid", {31'h0, id_valid}, 32'h1);
        chk("mrst_load_pc4", id_pc4, 32'd4);
        chk("mrst_next_addr", imem_addr, 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
